// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with programmable wait states
// Executes byte/half/word loads and stores against an internal word array.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iAddress,
    input  logic [31:0] iData,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    output logic [31:0] oData,
    output logic        oReady,
    output logic        oFault,
    output logic        oBusy
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    state_t           nextState;
    logic [3:0]       waitCnt;
    logic [IDX_W+1:0] addrQ;
    logic [31:0]      dataQ;
    logic [1:0]       sizeQ;
    logic             unsQ;
    logic             writeQ;
    logic             faultQ;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             reqFault;
    logic             enterResp;
    logic             inIdle;
    logic [IDX_W+1:0] curAddr;
    logic [31:0]      curData;
    logic [1:0]       curSize;
    logic             curUns;
    logic             curWrite;
    logic             curFault;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      rdWord;
    logic [7:0]       byteVal;
    logic [15:0]      halfVal;
    logic [31:0]      loadVal;
    logic [31:0]      wrWord;
    logic [3:0]       laneEn;

    always_comb begin
        reqFault = 1'b0;
        if (read && write) reqFault = 1'b1;
        if ({1'b0, iAddress} >= BYTE_LIMIT) reqFault = 1'b1;
        case (iSize)
            2'b01:   if (iAddress[0]) reqFault = 1'b1;
            2'b10:   if (iAddress[1:0] != 2'b00) reqFault = 1'b1;
            2'b11:   reqFault = 1'b1;
            default: ;
        endcase
    end

    assign inIdle = (state == IDLE);
    assign accept = inIdle && (read || write);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (read || write) nextState = (WAIT_STATES > 0) ? WAIT : RESP;
            WAIT:    if (waitCnt == 4'd0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterResp = (nextState == RESP) && (state != RESP);

    // With zero wait states the access executes on the acceptance edge, before
    // the request registers hold anything, so the live inputs are used then.
    assign curAddr  = inIdle ? iAddress[IDX_W+1:0] : addrQ;
    assign curData  = inIdle ? iData : dataQ;
    assign curSize  = inIdle ? iSize : sizeQ;
    assign curUns   = inIdle ? iUnsigned : unsQ;
    assign curWrite = inIdle ? write : writeQ;
    assign curFault = inIdle ? reqFault : faultQ;

    assign wordIdx = curAddr[IDX_W+1:2];
    assign rdWord  = mem[wordIdx];
    assign byteVal = rdWord[{curAddr[1:0], 3'b000} +: 8];
    assign halfVal = curAddr[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        loadVal = rdWord;
        laneEn  = 4'b0000;
        wrWord  = curData;
        case (curSize)
            2'b00: begin
                loadVal = curUns ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
                laneEn  = 4'b0001 << curAddr[1:0];
                wrWord  = {4{curData[7:0]}};
            end
            2'b01: begin
                loadVal = curUns ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
                laneEn  = curAddr[1] ? 4'b1100 : 4'b0011;
                wrWord  = {2{curData[15:0]}};
            end
            2'b10: laneEn = 4'b1111;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
            addrQ   <= '0;
            dataQ   <= 32'd0;
            sizeQ   <= 2'd0;
            unsQ    <= 1'b0;
            writeQ  <= 1'b0;
            faultQ  <= 1'b0;
            oReady  <= 1'b0;
            oFault  <= 1'b0;
            oData   <= 32'd0;
        end else begin
            state  <= nextState;
            oReady <= (state == RESP);
            oFault <= (state == RESP) && faultQ;
            if (accept) begin
                addrQ   <= iAddress[IDX_W+1:0];
                dataQ   <= iData;
                sizeQ   <= iSize;
                unsQ    <= iUnsigned;
                writeQ  <= write;
                faultQ  <= reqFault;
                waitCnt <= WAIT_LOAD;
            end else if (state == WAIT && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (enterResp && !curWrite && !curFault) oData <= loadVal;
        end
    end

    // The array has no reset so its contents survive an aborted access.
    always_ff @(posedge clock) begin
        if (enterResp && curWrite && !curFault) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
            end
        end
    end

    assign oBusy = (state != IDLE);

endmodule
